// File: rtl/iob_ram_responder.sv
// Native iob memory responder: word-addressed single-port RAM with byte-enable writes and a
// fixed-latency, fully pipelined, in-order response path. Out-of-range accesses raise a sticky err.
module iob_ram_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int LATENCY    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [1+ADDR_W+DATA_W+DATA_W/8-1:0]    req,
    output logic [DATA_W:0]                        resp,
    output logic                                   err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int DEPTH  = 2 ** MEM_ADDR_W;

    // Handshake: every cycle with req.valid=1 is one accepted request (no stall path); exactly
    // one resp.ready pulse returns per request, LATENCY cycles later, in request order, and
    // resp.rdata is zero whenever resp.ready is zero.
    logic                  req_valid;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [STRB_W-1:0]     req_wstrb;

    assign req_valid = req[REQ_W-1];
    assign req_addr  = req[ADDR_W+DATA_W+STRB_W-1 -: ADDR_W];
    assign req_wdata = req[DATA_W+STRB_W-1 -: DATA_W];
    assign req_wstrb = req[STRB_W-1:0];

    logic                  accept;
    logic                  is_write;
    logic                  out_of_range;
    logic [MEM_ADDR_W-1:0] word_idx;
    logic                  unused_addr_lsb;

    assign word_idx        = req_addr[MEM_ADDR_W+1:2];
    assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

    generate
        if (ADDR_W > MEM_ADDR_W + 2) begin : g_range_check
            assign out_of_range = |req_addr[ADDR_W-1:MEM_ADDR_W+2];
        end else begin : g_no_range_check
            assign out_of_range = 1'b0;
        end
    endgenerate

    // Requests seen while rst is high are dropped entirely, including writes.
    assign accept   = req_valid && !rst;
    assign is_write = |req_wstrb;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    // RAM port and response data pipeline; stage 0 captures the registered read.
    always_ff @(posedge clk) begin
        if (accept && is_write && !out_of_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (req_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
        if (accept) begin
            data_q[0] <= (!is_write && !out_of_range) ? mem[word_idx] : '0;
        end
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && out_of_range) begin
            err <= 1'b1;
        end
    end

    // Gating rdata with ready lets several responders be OR-combined downstream.
    assign resp = {vld_q[LATENCY-1], vld_q[LATENCY-1] ? data_q[LATENCY-1] : {DATA_W{1'b0}}};

endmodule

// File: tb/tb_iob_ram_responder.sv
// Directed bench for iob_ram_responder: three instances (LATENCY 1, 3, 4) share one request
// stream; each checks its responses against the shared expected queue with its own latency.
module tb_iob_ram_responder;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 12;
    localparam int REQ_W      = 1 + ADDR_W + DATA_W + DATA_W / 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [REQ_W-1:0] req = '0;

    int          cyc       = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          flush_ptr = 0;
    logic        exp_err   = 1'b0;
    logic        checking  = 1'b0;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Presents one request for one cycle; acc_q holds the cycle count right after its accept edge.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rd);
        req = {1'b1, addr, wdata, wstrb};
        exp_q.push_back(exp_rd);
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        if (addr[31:14] != 18'd0) exp_err = 1'b1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One reset edge with a stray read presented; anything still in flight is expected to vanish.
    task automatic do_reset(input logic [31:0] stray_addr);
        rst = 1'b1;
        req = {1'b1, stray_addr, 32'h0, 4'h0};
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req       = '0;
        exp_err   = 1'b0;
        flush_ptr = exp_q.size();
        checking  = 1'b1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        logic [DATA_W:0] resp;
        logic            err;
        int              ptr = 0;

        iob_ram_responder #(
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W),
            .MEM_ADDR_W(MEM_ADDR_W),
            .LATENCY   (LAT)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .req (req),
            .resp(resp),
            .err (err)
        );

        always @(negedge clk) begin
            if (checking) begin
                if (ptr < flush_ptr) ptr = flush_ptr;
                if (resp[DATA_W]) begin
                    check($sformatf("ready_expected_l%0d", LAT),
                          (ptr < exp_q.size()) ? 32'd1 : 32'd0, 32'd1);
                    if (ptr < exp_q.size()) begin
                        check($sformatf("ready_cycle_l%0d", LAT), 32'(cyc), 32'(acc_q[ptr] + LAT - 1));
                        check($sformatf("rdata_l%0d", LAT), resp[DATA_W-1:0], exp_q[ptr]);
                        ptr++;
                    end
                end else begin
                    check($sformatf("idle_rdata_l%0d", LAT), resp[DATA_W-1:0], 32'h0);
                    if (ptr < exp_q.size() && cyc >= acc_q[ptr] + LAT - 1) begin
                        check($sformatf("missing_ready_l%0d", LAT), 32'd0, 32'd1);
                        ptr++;
                    end
                end
                check($sformatf("err_l%0d", LAT), {31'd0, err}, {31'd0, exp_err});
            end
        end
    end

    initial begin
        idle(2);
        do_reset(32'h0);

        // Preload word 5, reset again (RAM must survive), then read it back.
        issue(32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 32'h0);
        idle(4);
        do_reset(32'h0000_0014);
        issue(32'h0000_0014, 32'h0, 4'h0, 32'hDEAD_BEEF);
        idle(5);

        // Byte-strobe merge on word 0.
        issue(32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0);
        issue(32'h0000_0000, 32'hAABB_CCDD, 4'h5, 32'h0);
        issue(32'h0000_0000, 32'h0,         4'h0, 32'h11BB_33DD);
        idle(5);

        // Back-to-back: eight writes then eight continuous reads.
        for (int i = 0; i < 8; i++) issue(32'(i * 4), 32'(i) * 32'h0101_0101, 4'hF, 32'h0);
        for (int i = 0; i < 8; i++) issue(32'(i * 4), 32'h0, 4'h0, 32'(i) * 32'h0101_0101);
        idle(5);

        // Read immediately after write to the same word.
        issue(32'h0000_000C, 32'h1234_5678, 4'hF, 32'h0);
        issue(32'h0000_000C, 32'h0,         4'h0, 32'h1234_5678);
        idle(5);

        // Out-of-range accesses, low address bits ignored, high-bit aliasing.
        issue(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0);
        issue(32'h0000_4000, 32'h0, 4'h0, 32'h0);
        issue(32'h0000_0000, 32'h0, 4'h0, 32'h0);
        issue(32'h0000_0017, 32'h0, 4'h0, 32'h0505_0505);
        issue(32'h8000_0000, 32'h0, 4'h0, 32'h0);
        idle(5);

        // Reset with three reads in flight; a stray read during reset must be ignored.
        issue(32'h0000_0004, 32'h0, 4'h0, 32'h0101_0101);
        issue(32'h0000_0008, 32'h0, 4'h0, 32'h0202_0202);
        issue(32'h0000_001C, 32'h0, 4'h0, 32'h0707_0707);
        do_reset(32'h0000_0010);
        idle(6);
        issue(32'h0000_0018, 32'h0, 4'h0, 32'h0606_0606);
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iob_ram_responder.md
# iob_ram_responder

Native iob bus responder backed by an on-chip word-addressed RAM. It is the memory-side end of the request/response bus that the CPU wrappers drive: the instruction port and the data port of the core each connect to one instance. Every accepted request is served without back-pressure, and responses return in order after a fixed, parameterised latency. Back-to-back requests are fully pipelined.

## Interface
- `ADDR_W`, 32: request address width (byte address).
- `DATA_W`, 32: data width. Only 32 is supported.
- `MEM_ADDR_W`, 12: log2 of the RAM depth in words. Memory size is 4·2^MEM_ADDR_W bytes.
- `LATENCY`, 1: cycles from request to response, 1..4.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `req`, in, `REQ_W`: packed request. Fields are extracted with the intercon field macros `valid(0)`, `address(0,ADDR_W)`, `wdata(0)` and `wstrb(0)`.
- `resp`, out, `RESP_W`: packed response. Fields are `ready(0)` and `rdata(0)`.
- `err`, out, 1: sticky flag for an out-of-range access.

## Operation
- **Acceptance.** A request is accepted in every cycle where valid=1 at the rising edge of `clk`.
  - There is no stall. Upstream ties its command-ready to its own valid, so each valid cycle is exactly one request.
  - valid held high for N cycles means N requests.
- **Request type.**
  - wstrb==0 is a read.
  - wstrb!=0 is a write. Lane i (bits 8i+7:8i) is written only where wstrb[i]=1; all other lanes keep their old data.
- **Word index.** The word index is address[MEM_ADDR_W+1:2]. address[1:0] is ignored.
- **Out of range.** An access is out of range when any bit of address[ADDR_W-1:MEM_ADDR_W+2] is nonzero.
  - A write is dropped.
  - A read returns 0.
  - The access is still responded to normally, so the requester can never hang.
  - `err` is set to 1 and stays 1 until `rst`.
- **Response pipeline.** The pipeline has LATENCY stages. Each stage holds a valid bit and the read data (a write carries data 0).
  - Stage 1 is loaded on the accept edge with the RAM read of the addressed word.
  - Each following stage shifts by one every cycle.
  - The stage LATENCY outputs drive `resp`.
- **Write responses.** A write produces one response pulse with rdata=0.
- **Ordering.** Responses leave in strict request order, and there is exactly one ready pulse per accepted request.
- **Read/write collisions.**
  - Read after write: a write accepted at edge t updates the RAM at edge t. A read of the same word accepted at edge t+1 returns the new data.
  - A read and a write cannot be accepted in the same cycle, because there is a single request port.

## Timing
- **Reset values.** On `rst`=1 at a clock edge:
  - All pipeline valid bits are cleared.
  - `resp.ready`=0 and `resp.rdata`=0.
  - `err`=0.
  - RAM contents are not reset.
- **Reset mid-operation.** In-flight responses are discarded. No ready pulse appears for requests accepted before or during reset.
  - Requests presented while `rst`=1 are ignored.
  - The first acceptance happens at the first edge with `rst`=0.
- **Latency.** A request accepted at edge t produces `resp.ready`=1 for exactly one cycle, the cycle following edge t+LATENCY-1. For LATENCY=1 this is the cycle right after acceptance.
- **Response data.**
  - rdata is valid in the same cycle as ready.
  - rdata is forced to 0 whenever ready=0, so responses can be OR-combined in the interconnect.
- **Throughput.** One request per cycle is sustained. Valid asserted continuously for N cycles gives ready asserted continuously for N cycles, delayed by LATENCY.
- **Write timing.** A write takes effect at the accept edge, independent of LATENCY.
- **`err` timing.** `err` rises on the accept edge of the first out-of-range request.
- **Implementation.** The RAM is inferred as a synchronous single-port array with byte-enable writes. Read data is registered once in stage 1; there are no combinational paths from `req` to `resp`.

## Test plan
- **Reset then single read.** Preload word 5 = 0xDEADBEEF. Release `rst`, then request a read at 0x14.
  - Expect ready=1 with rdata=0xDEADBEEF exactly LATENCY cycles later, then ready=0 and rdata=0.
- **Byte-strobe write, then readback.** Start with word 0 = 0x11223344.
  - Write 0xAABBCCDD to word 0 with wstrb=0b0101. The write response has rdata=0.
  - Then read word 0. Expect rdata=0x11BB33DD.
- **Back-to-back pipelining.** Valid held high for 8 cycles, reading words 0..7 (preloaded with i·0x01010101).
  - Expect 8 consecutive ready cycles with those values in order, starting LATENCY cycles after the first request.
- **Read-after-write hazard.** Write 0x12345678 to word 3, then read word 3 in the next cycle.
  - Expect 0x12345678. Run for LATENCY=1 and LATENCY=4.
- **Out of range.** With MEM_ADDR_W=12, write 0xFFFFFFFF to address 0x4000, then read address 0x4000, then read address 0x0000.
  - Expect both out-of-range accesses to get a response, the read returning 0.
  - Expect word 0 unchanged.
  - Expect `err`=1 from the write's accept edge until `rst`.
- **Reset mid-operation.** With LATENCY=3, issue 3 reads, assert `rst` for 1 cycle on the edge after the third request, then release it.
  - Expect no ready pulses after reset.
  - Expect `err`=0.
  - A new read afterwards must return correct data after 3 cycles.
